// File: rtl/bias_dac_loader.sv
// Purpose : serial loader for the on-chip bias DACs; frames {addr, code} words MSB first under cs_n.
// Latency : start edge at k -> frame c on cs_n from k+1+c*(ADDR_W+DATA_W+GAP_CYCLES); done pulse follows the last frame.
// Backpr. : none; a start edge while a load is in progress is dropped (no queueing).
//
// Ports   : input_shiftclk/reset (sync, active-high); start level from host (rising edge triggers);
//           bias_in packed codes (channel c at [c*DATA_W +: DATA_W]); sdo DAC readback;
//           cs_n/sclk/sdata DAC programming pins; busy/done status; readback/mismatch status.
// Option  : define BIAS_READBACK_EN to capture sdo into readback and flag mismatch;
//           otherwise sdo is ignored and readback/mismatch are tied to zero.
module bias_dac_loader #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 10
) (
    input  logic                     input_shiftclk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_CH*DATA_W-1:0] bias_in,
    input  logic                     sdo,
    output logic                     cs_n,
    output logic                     sclk,
    output logic                     sdata,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_CH*DATA_W-1:0] readback,
    output logic                     mismatch
);

    localparam int WORD_W = ADDR_W + DATA_W;
    localparam int BIT_W  = $clog2(WORD_W);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FRAME,
        S_GAP,
        S_DONE
    } state_t;

    state_t                    state, state_nx;
    logic [BIT_W-1:0]          bit_cnt, bit_nx;
    logic [CH_W-1:0]           ch, ch_nx;
    logic [GAP_W-1:0]          gap_cnt, gap_nx;
    logic [NUM_CH*DATA_W-1:0]  shadow, shadow_nx;
    logic [WORD_W-1:0]         word_nx;
    logic [BIT_W-1:0]          sel_nx;
    logic                      sdata_nx;
    logic                      start_d;
    logic                      trig;

    assign trig = start & ~start_d;

    // Only pulses inside a frame; cs_n and input_shiftclk both change on the
    // rising edge, when ~input_shiftclk is already low, so no runt pulse.
    assign sclk = ~cs_n & ~input_shiftclk;

    always_comb begin
        state_nx  = state;
        bit_nx    = bit_cnt;
        ch_nx     = ch;
        gap_nx    = gap_cnt;
        shadow_nx = shadow;
        case (state)
            S_IDLE: begin
                if (trig) state_nx = S_LOAD;
            end
            S_LOAD: begin
                shadow_nx = bias_in;
                ch_nx     = '0;
                bit_nx    = '0;
                gap_nx    = '0;
                state_nx  = S_FRAME;
            end
            S_FRAME: begin
                if (bit_cnt == BIT_LAST) begin
                    gap_nx   = '0;
                    state_nx = (ch == CH_LAST) ? S_DONE : S_GAP;
                end else begin
                    bit_nx = bit_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nx   = '0;
                    ch_nx    = ch + 1'b1;
                    bit_nx   = '0;
                    state_nx = S_FRAME;
                end else begin
                    gap_nx = gap_cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Pin outputs are registered from the next-state view so each pin
    // changes exactly on the edge the state does.
    always_comb begin
        word_nx  = {ADDR_W'(ch_nx), shadow_nx[int'(ch_nx)*DATA_W +: DATA_W]};
        sel_nx   = BIT_LAST - bit_nx;
        sdata_nx = (state_nx == S_FRAME) ? word_nx[sel_nx] : 1'b0;
    end

    always_ff @(posedge input_shiftclk) begin
        // start_d follows start even in reset, so a level already high at
        // reset release is not mistaken for a fresh request.
        start_d <= start;
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            ch      <= '0;
            gap_cnt <= '0;
            shadow  <= '0;
            cs_n    <= 1'b1;
            sdata   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_nx;
            ch      <= ch_nx;
            gap_cnt <= gap_nx;
            shadow  <= shadow_nx;
            cs_n    <= (state_nx != S_FRAME);
            sdata   <= sdata_nx;
            busy    <= (state_nx == S_LOAD) || (state_nx == S_FRAME) || (state_nx == S_GAP);
            done    <= (state_nx == S_DONE);
        end
    end

`ifdef BIAS_READBACK_EN
    logic [NUM_CH*DATA_W-1:0] rb_q;
    logic                     mm_q;

    // The DAC drives sdo on sclk rising (mid-bit); it is taken on the rising
    // edge that ends each data bit, so the last one lands on the edge into DONE.
    always_ff @(posedge input_shiftclk) begin
        if (reset) begin
            rb_q <= '0;
            mm_q <= 1'b0;
        end else begin
            if (state == S_FRAME && bit_cnt >= BIT_W'(ADDR_W)) begin
                rb_q[int'(ch)*DATA_W +: DATA_W] <= {rb_q[int'(ch)*DATA_W +: (DATA_W-1)], sdo};
            end
            if (state == S_IDLE && trig) begin
                mm_q <= 1'b0;
            end else if (state == S_DONE) begin
                mm_q <= (rb_q != shadow);
            end
        end
    end

    assign readback = rb_q;
    assign mismatch = mm_q;
`else
    logic unused_sdo;
    assign unused_sdo = sdo;
    assign readback   = '0;
    assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_bias_dac_loader.sv
// Purpose : scoreboard bench for bias_dac_loader (default parameters).
// Latency : expected frames/done/busy windows are queued at stimulus time, popped by the monitor.
// Backpr. : n/a; define BIAS_READBACK_EN to also exercise the readback path.
module tb_bias_dac_loader;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        sdo      = 1'b0;
    logic [31:0] bias_in  = '0;
    logic        cs_n, sclk, sdata, busy, done, mismatch;
    logic [31:0] readback;

    bias_dac_loader #(
        .NUM_CH(4), .ADDR_W(2), .DATA_W(8), .GAP_CYCLES(10)
    ) dut (
        .input_shiftclk(clk),
        .reset(reset),
        .start(start),
        .bias_in(bias_in),
        .sdo(sdo),
        .cs_n(cs_n),
        .sclk(sclk),
        .sdata(sdata),
        .busy(busy),
        .done(done),
        .readback(readback),
        .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge n, cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         at;
        logic [9:0] word;
    } frame_t;

    frame_t exp_frames[$];
    int     exp_done[$];
    int     exp_brise[$];
    int     exp_bfall[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
    endtask

    // ---------------- monitor ----------------
    logic [9:0] cur        = '0;
    int         cnt        = 0;
    int         hi         = 0;
    int         gap_pulses = 0;
    int         fstart     = 0;
    int         bstart     = 0;
    logic       busy_prev  = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            // an aborted frame is dropped, never scored
            cnt = 0;
            hi  = 0;
        end else if (!cs_n) begin
            if (cnt == 0) begin
                fstart = cyc;
                check("sclk_idle_pulses", gap_pulses, 0);
                gap_pulses = 0;
            end
            cur = {cur[8:0], sdata};
            cnt++;
            if (sclk) hi++;
        end else begin
            if (sclk) gap_pulses++;
            if (cnt > 0) begin
                if (exp_frames.size() == 0) begin
                    unexpected("frame");
                end else begin
                    frame_t f;
                    f = exp_frames.pop_front();
                    check("frame_word", cur, f.word);
                    check("frame_start", fstart, f.at);
                    check("frame_len", cnt, 10);
                    check("frame_sclk", hi, 10);
                end
                cnt = 0;
                hi  = 0;
            end
        end

        if (busy && !busy_prev) bstart = cyc;
        if (!busy && busy_prev) begin
            if (exp_bfall.size() == 0) begin
                unexpected("busy_window");
            end else begin
                check("busy_rise", bstart, exp_brise.pop_front());
                check("busy_fall", cyc, exp_bfall.pop_front());
            end
        end
        busy_prev = busy;

        if (done) begin
            if (exp_done.size() == 0) unexpected("done");
            else check("done_cycle", cyc, exp_done.pop_front());
        end
    end

    // ---------------- DAC sdo model ----------------
    logic corrupt = 1'b0;
`ifdef BIAS_READBACK_EN
    int         drv_pos  = 0;
    logic [1:0] drv_addr = '0;
    always @(negedge clk) begin
        if (cs_n) begin
            drv_pos = 0;
            sdo     = 1'b0;
        end else begin
            if (drv_pos == 0) drv_addr[1] = sdata;
            if (drv_pos == 1) drv_addr[0] = sdata;
            sdo = sdata ^ (corrupt && drv_addr == 2'd2 && drv_pos == 9);
            drv_pos++;
        end
    end
`endif

    // ---------------- stimulus ----------------
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] bias, input logic [9:0] w0, w1, w2, w3,
                         input int abort_at, output int k);
        logic [9:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        @(negedge clk);
        bias_in = bias;
        start   = 1'b1;
        k       = cyc + 1;
        for (int c = 0; c < 4; c++) begin
            if (abort_at < 0 || (1 + 20*c + 10) <= abort_at)
                exp_frames.push_back('{k + 1 + 20*c, w[c]});
        end
        if (abort_at < 0) exp_done.push_back(k + 71);
        exp_brise.push_back(k);
        exp_bfall.push_back(abort_at < 0 ? k + 71 : k + abort_at);
    endtask

    initial begin
        int k;

        // reset with start held high through release
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_sdata", sdata, 0);
        check("rst_sclk", sclk, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_readback", readback, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("no_load_busy", busy, 0);
        check("no_load_cs_n", cs_n, 1);
        start = 1'b0;
        @(negedge clk);

        // all channels 0x80
        issue(32'h80808080, 10'h080, 10'h180, 10'h280, 10'h380, -1, k);
        wait_until(k + 75);
        start = 1'b0;
`ifdef BIAS_READBACK_EN
        check("rb_echo_a", readback, 32'h80808080);
        check("mm_echo_a", mismatch, 0);
`endif

        // mixed codes, bias_in cleared mid-load, ignored retrigger at k+30
        issue(32'hA53CFF01, 10'h001, 10'h1FF, 10'h23C, 10'h3A5, -1, k);
        wait_until(k + 4);
        bias_in = '0;
        wait_until(k + 20);
        start = 1'b0;
        wait_until(k + 29);
        start = 1'b1;
        wait_until(k + 75);
        start = 1'b0;
`ifdef BIAS_READBACK_EN
        check("rb_echo_b", readback, 32'hA53CFF01);
        check("mm_echo_b", mismatch, 0);

        // corrupt channel 2 code bit 0 on readback
        corrupt = 1'b1;
        issue(32'h80808080, 10'h080, 10'h180, 10'h280, 10'h380, -1, k);
        wait_until(k + 75);
        start = 1'b0;
        check("rb_corrupt", readback, 32'h80818080);
        check("mm_corrupt", mismatch, 1);
        corrupt = 1'b0;
`endif

        // reset mid frame 1
        issue(32'h12345678, 10'h078, 10'h000, 10'h000, 10'h000, 25, k);
`ifdef BIAS_READBACK_EN
        wait_until(k);
        check("mm_cleared_by_start", mismatch, 0);
`endif
        wait_until(k + 24);
        reset = 1'b1;
        wait_until(k + 25);
        check("abort_cs_n", cs_n, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        wait_until(k + 100);

        // fresh load after abort
        issue(32'h0F1E2D3C, 10'h03C, 10'h12D, 10'h21E, 10'h30F, -1, k);
        wait_until(k + 80);
        start = 1'b0;

        check("frames_left", exp_frames.size(), 0);
        check("done_left", exp_done.size(), 0);
        check("busy_left", exp_bfall.size(), 0);
`ifndef BIAS_READBACK_EN
        check("rb_tied", readback, 0);
        check("mm_tied", mismatch, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
